sram_param: RTL and testbench

//  Parametrised single-port synchronous SRAM model for the example DUT. Replaces
//  the fixed 32-bit dummy SRAM with configurable width/depth, byte write enables,
//  a pipelined read latency with a valid strobe, and out-of-range error reporting.

---
 rtl/sram_param.sv | 121 ++++++++++++
 tb/tb_sram_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sram_param.sv
// Parametrised single-port synchronous SRAM with byte enables, pipelined read latency and
// range errors. Optional saturating access counters enabled with `define SRAM_STATS_EN.
module sram_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  we_n,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   be_n,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  rerr,
  output logic                  werr,
  output logic [15:0]           wr_cnt,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           err_cnt
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned Last     = RD_LAT - 1;
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $fatal(1, "sram_param: RD_LAT must be in 1..4");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $fatal(1, "sram_param: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic            rd_req, wr_req, in_range;
  logic [IdxW-1:0] idx;

  // Full-width compare: out-of-range addresses never alias onto the array.
  assign in_range = ({1'b0, addr} < DepthExt);
  assign idx      = addr[IdxW-1:0];
  assign rd_req   = ~cs_n & we_n;
  assign wr_req   = ~cs_n & ~we_n;

  always_ff @(posedge clk) begin
    if (wr_req && in_range) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (!be_n[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  logic [RD_LAT-1:0] pipe_v_q, pipe_e_q;
  logic [DATA_W-1:0] pipe_d_q [RD_LAT];
  logic              werr_q;

  // Data stages only load behind a valid entry, so the last stage holds the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q <= '0;
      pipe_e_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_d_q[i] <= '0;
      werr_q   <= 1'b0;
    end else begin
      pipe_v_q[0] <= rd_req;
      pipe_e_q[0] <= rd_req & ~in_range;
      if (rd_req) pipe_d_q[0] <= in_range ? mem[idx] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_e_q[i] <= pipe_e_q[i-1];
        if (pipe_v_q[i-1]) pipe_d_q[i] <= pipe_d_q[i-1];
      end
      werr_q <= wr_req & ~in_range;
    end
  end

  assign rvalid = pipe_v_q[Last];
  assign rerr   = pipe_v_q[Last] & pipe_e_q[Last];
  assign rdata  = pipe_d_q[Last];
  assign werr   = werr_q;

`ifdef SRAM_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q, err_cnt_q;
  logic [15:0] wr_cnt_d, rd_cnt_d, err_cnt_d;
  logic [16:0] wr_sum, rd_sum, err_sum;

  always_comb begin
    wr_sum    = {1'b0, wr_cnt_q} + 17'(wr_req & in_range);
    rd_sum    = {1'b0, rd_cnt_q} + 17'(rd_req & in_range);
    // A write error and a read error can land in the same cycle.
    err_sum   = {1'b0, err_cnt_q} + 17'(werr_q) + 17'(rerr);
    wr_cnt_d  = wr_sum[16] ? 16'hFFFF : wr_sum[15:0];
    rd_cnt_d  = rd_sum[16] ? 16'hFFFF : rd_sum[15:0];
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign wr_cnt  = wr_cnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign wr_cnt  = '0;
  assign rd_cnt  = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_param.sv
// Directed bench for sram_param: one RD_LAT=3 and one RD_LAT=1 instance on shared stimulus.
module tb_sram_param;

  logic        clk = 1'b0;
  logic        rst_n, cs_n, we_n;
  logic [31:0] addr, wdata;
  logic [3:0]  be_n;

  logic [31:0] rdata3, rdata1;
  logic        rvalid3, rvalid1, rerr3, rerr1, werr3, werr1;
  logic [15:0] wr_cnt3, rd_cnt3, err_cnt3, wr_cnt1, rd_cnt1, err_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_param #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .we_n(we_n), .addr(addr), .be_n(be_n),
    .wdata(wdata), .rdata(rdata3), .rvalid(rvalid3), .rerr(rerr3), .werr(werr3),
    .wr_cnt(wr_cnt3), .rd_cnt(rd_cnt3), .err_cnt(err_cnt3)
  );

  sram_param #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .we_n(we_n), .addr(addr), .be_n(be_n),
    .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1), .rerr(rerr1), .werr(werr1),
    .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1), .err_cnt(err_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs_n = 1'b1; we_n = 1'b1; be_n = 4'hF;
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    cs_n = 1'b0; we_n = 1'b0; addr = a; wdata = d; be_n = b;
    step();
  endtask

  task automatic rd(input logic [31:0] a);
    cs_n = 1'b0; we_n = 1'b1; addr = a; be_n = 4'hF;
    step();
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; we_n = 1'b1; addr = '0; wdata = '0; be_n = 4'hF;
    #1;
    check("reset_rvalid3", 32'(rvalid3), 32'd0);
    check("reset_rdata3", rdata3, 32'd0);
    check("reset_rerr1", 32'(rerr1), 32'd0);
    check("reset_werr1", 32'(werr1), 32'd0);
    step(); step();
    rst_n = 1'b1;

    // Byte enables
    wr(32'd5, 32'h11223344, 4'b0000);
    wr(32'd5, 32'hAABBCCDD, 4'b1010);
    rd(32'd5);
    check("be_lat1_valid", 32'(rvalid1), 32'd1);
    check("be_lat1_data", rdata1, 32'h11BB33DD);
    check("be_lat3_early", 32'(rvalid3), 32'd0);
    idle();
    check("lat1_drop", 32'(rvalid1), 32'd0);
    check("lat1_hold", rdata1, 32'h11BB33DD);
    check("lat3_early2", 32'(rvalid3), 32'd0);
    idle();
    check("be_lat3_valid", 32'(rvalid3), 32'd1);
    check("be_lat3_data", rdata3, 32'h11BB33DD);
    idle();
    check("be_lat3_drop", 32'(rvalid3), 32'd0);

    // Back-to-back reads with RD_LAT=3
    wr(32'd0, 32'hA0A0A0A0, 4'h0);
    wr(32'd1, 32'hA1A1A1A1, 4'h0);
    wr(32'd2, 32'hA2A2A2A2, 4'h0);
    rd(32'd0);
    check("b2b_lat1_0", rdata1, 32'hA0A0A0A0);
    rd(32'd1);
    check("b2b_lat1_1", rdata1, 32'hA1A1A1A1);
    check("b2b_lat3_pre", 32'(rvalid3), 32'd0);
    rd(32'd2);
    check("b2b_lat1_2", rdata1, 32'hA2A2A2A2);
    check("b2b_v0", 32'(rvalid3), 32'd1);
    check("b2b_d0", rdata3, 32'hA0A0A0A0);
    idle();
    check("b2b_v1", 32'(rvalid3), 32'd1);
    check("b2b_d1", rdata3, 32'hA1A1A1A1);
    idle();
    check("b2b_v2", 32'(rvalid3), 32'd1);
    check("b2b_d2", rdata3, 32'hA2A2A2A2);
    idle();
    check("b2b_end", 32'(rvalid3), 32'd0);
    check("b2b_hold3", rdata3, 32'hA2A2A2A2);

    // Out of range
    wr(32'd1024, 32'hFFFFFFFF, 4'h0);
    check("oob_werr3", 32'(werr3), 32'd1);
    check("oob_werr1", 32'(werr1), 32'd1);
    idle();
    check("oob_werr_pulse", 32'(werr3), 32'd0);
    rd(32'd0);
    check("oob_no_alias1", rdata1, 32'hA0A0A0A0);
    rd(32'd1024);
    check("oob_rd_v1", 32'(rvalid1), 32'd1);
    check("oob_rd_e1", 32'(rerr1), 32'd1);
    check("oob_rd_d1", rdata1, 32'd0);
    idle();
    check("oob_rerr_clr1", 32'(rerr1), 32'd0);
    check("oob_no_alias3", rdata3, 32'hA0A0A0A0);
    check("oob_e3_pre", 32'(rerr3), 32'd0);
    idle();
    check("oob_rd_v3", 32'(rvalid3), 32'd1);
    check("oob_rd_e3", 32'(rerr3), 32'd1);
    check("oob_rd_d3", rdata3, 32'd0);
    idle();
    check("oob_rerr_clr3", 32'(rerr3), 32'd0);

    // Write then immediate read
    wr(32'd7, 32'hDEADBEEF, 4'h0);
    rd(32'd7);
    check("wtr_lat1", rdata1, 32'hDEADBEEF);
    idle(); idle();
    check("wtr_lat3", rdata3, 32'hDEADBEEF);
    check("wtr_lat3_v", 32'(rvalid3), 32'd1);

    // Reset mid-read
    rd(32'd7);
    check("mid_pre_v1", 32'(rvalid1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_v1", 32'(rvalid1), 32'd0);
    check("async_d1", rdata1, 32'd0);
    check("async_d3", rdata3, 32'd0);
    cs_n = 1'b1; we_n = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("flush_v3", 32'(rvalid3), 32'd0);
      check("flush_v1", 32'(rvalid1), 32'd0);
    end
    rd(32'd7);
    check("mem_kept", rdata1, 32'hDEADBEEF);
    idle(); idle();

`ifdef SRAM_STATS_EN
    rst_n = 1'b0;
    #1;
    check("cnt_rst_wr", 32'(wr_cnt3), 32'd0);
    check("cnt_rst_rd", 32'(rd_cnt1), 32'd0);
    step();
    rst_n = 1'b1;
    wr(32'd10, 32'h1, 4'h0);
    wr(32'd11, 32'h2, 4'h0);
    wr(32'd12, 32'h3, 4'h0);
    rd(32'd10);
    rd(32'd11);
    wr(32'd2000, 32'h4, 4'h0);
    for (int i = 0; i < 4; i++) idle();
    check("cnt_wr3", 32'(wr_cnt3), 32'd3);
    check("cnt_rd3", 32'(rd_cnt3), 32'd2);
    check("cnt_err3", 32'(err_cnt3), 32'd1);
    check("cnt_err1", 32'(err_cnt1), 32'd1);
    for (int i = 0; i < 70000; i++) wr(32'(i % 1024), 32'(i), 4'h0);
    idle();
    check("cnt_wr_sat", 32'(wr_cnt3), 32'h0000FFFF);
    check("cnt_rd_keep", 32'(rd_cnt3), 32'd2);
`else
    check("tie_wr", 32'(wr_cnt3), 32'd0);
    check("tie_rd", 32'(rd_cnt1), 32'd0);
    check("tie_err", 32'(err_cnt3), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
